// File: rtl/lcd_pkg.sv
// Shared state encoding, HD44780 instruction constants and cursor tracking helpers
// for the LCD character writer.
package lcd_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        SETUP,
        PULSO,
        HOLD,
        ESPERA
    } estado_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_DDRAM = 8'h80;
    localparam logic [7:0] LINHA2    = 8'h40;

    localparam logic [4:0] CURSOR_LINHA1 = 5'd0;
    localparam logic [4:0] CURSOR_LINHA2 = 5'd16;

    // Clear (0x01) and both home encodings (0x02/0x03) need the long execution time.
    function automatic logic espera_longa(input logic [7:0] dado);
        return (dado == CMD_CLEAR) || (dado[7:1] == CMD_HOME[7:1]);
    endfunction

    function automatic logic [4:0] proximo_cursor(
        input logic [4:0] atual,
        input logic [7:0] dado,
        input logic       comando
    );
        logic [4:0] prox;
        prox = atual;
        if (!comando) begin
            prox = atual + 5'd1;
        end else if (espera_longa(dado)) begin
            prox = CURSOR_LINHA1;
        end else if (dado[7:4] == CMD_DDRAM[7:4]) begin
            prox = {1'b0, dado[3:0]};
        end else if (dado[7:4] == (CMD_DDRAM[7:4] | LINHA2[7:4])) begin
            // Line-2 DDRAM address 0x40+n maps onto tracked position 16+n.
            prox = {1'b1, dado[3:0]};
        end
        return prox;
    endfunction

endpackage

// File: rtl/lcd_pulso_e.sv
// Enable-strobe timing engine: SETUP -> PULSO -> HOLD -> ESPERA from a start strobe,
// all phases counted by a single down-counter; Concluido pulses on the last wait cycle.
module lcd_pulso_e
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSO = 12,
    parameter int T_HOLD  = 2,
    parameter int CW      = 17
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Inicio,
    input  logic [CW-1:0] Espera,
    output estado_t       Estado,
    output logic          Enable,
    output logic          Concluido
);

    estado_t       estado;
    estado_t       estado_prox;
    logic [CW-1:0] cont;
    logic [CW-1:0] cont_prox;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado <= OCIOSO;
            cont   <= '0;
            Enable <= 1'b0;
        end else begin
            estado <= estado_prox;
            cont   <= cont_prox;
            // Registered so the LCD E line is decoded glitch-free.
            Enable <= (estado_prox == PULSO);
        end
    end

    always_comb begin
        estado_prox = estado;
        cont_prox   = cont;
        Concluido   = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (Inicio) begin
                    estado_prox = SETUP;
                    cont_prox   = CW'(T_SETUP - 1);
                end
            end
            SETUP: begin
                if (cont == '0) begin
                    estado_prox = PULSO;
                    cont_prox   = CW'(T_PULSO - 1);
                end else begin
                    cont_prox = cont - CW'(1);
                end
            end
            PULSO: begin
                if (cont == '0) begin
                    estado_prox = HOLD;
                    cont_prox   = CW'(T_HOLD - 1);
                end else begin
                    cont_prox = cont - CW'(1);
                end
            end
            HOLD: begin
                if (cont == '0) begin
                    estado_prox = ESPERA;
                    cont_prox   = Espera - CW'(1);
                end else begin
                    cont_prox = cont - CW'(1);
                end
            end
            ESPERA: begin
                if (cont == '0) begin
                    Concluido = 1'b1;
                    // A start on the final wait cycle chains straight into a new SETUP.
                    if (Inicio) begin
                        estado_prox = SETUP;
                        cont_prox   = CW'(T_SETUP - 1);
                    end else begin
                        estado_prox = OCIOSO;
                    end
                end else begin
                    cont_prox = cont - CW'(1);
                end
            end
            default: begin
                estado_prox = OCIOSO;
                cont_prox   = '0;
            end
        endcase
    end

    assign Estado = estado;

endmodule

// File: rtl/lcd_escritor_caracteres.sv
// HD44780 character/instruction writer with cursor tracking.
// Optional LCD_AUTOWRAP_EN: re-address DDRAM automatically when the cursor crosses a line end.
module lcd_escritor_caracteres
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSO = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_CLEAR = 80000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Inicializado,
    input  logic       Valido,
    input  logic [7:0] Dado,
    input  logic       Comando,
    output logic       Pronto,
    output logic       Enable,
    output logic       RS,
    output logic       RW,
    output logic [7:0] Dados,
    output logic [4:0] Cursor
);

    localparam int T_M1    = (T_SETUP > T_PULSO) ? T_SETUP : T_PULSO;
    localparam int T_M2    = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int T_M3    = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int T_MAIOR = (T_M3 > T_CLEAR) ? T_M3 : T_CLEAR;
    localparam int CW      = $clog2(T_MAIOR + 1);

    estado_t       estado;
    logic          concluido;
    logic          ocioso;
    logic          aceite;
    logic          dispara_wrap;
    logic          inicio;
    logic          longa;
    logic          pendente;
    logic [7:0]    cmd_wrap;
    logic [4:0]    cursor_prox;
    logic [CW-1:0] espera;

    assign ocioso       = (estado == OCIOSO);
    assign Pronto       = ocioso && Inicializado && !pendente;
    assign aceite       = Valido && Pronto;
    assign dispara_wrap = pendente && concluido;
    assign inicio       = aceite || dispara_wrap;
    assign cursor_prox  = proximo_cursor(Cursor, Dado, Comando);
    assign espera       = longa ? CW'(T_CLEAR) : CW'(T_EXEC);
    assign RW           = 1'b0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            RS       <= 1'b0;
            Dados    <= '0;
            Cursor   <= '0;
            longa    <= 1'b0;
            pendente <= 1'b0;
            cmd_wrap <= CMD_DDRAM;
        end else if (aceite) begin
            RS     <= ~Comando;
            Dados  <= Dado;
            Cursor <= cursor_prox;
            longa  <= Comando && espera_longa(Dado);
`ifdef LCD_AUTOWRAP_EN
            if (!Comando && (cursor_prox == CURSOR_LINHA2 || cursor_prox == CURSOR_LINHA1)) begin
                pendente <= 1'b1;
                cmd_wrap <= (cursor_prox == CURSOR_LINHA2) ? (CMD_DDRAM | LINHA2) : CMD_DDRAM;
            end
`endif
        end else if (dispara_wrap) begin
            // Cursor already holds the wrapped position; only the LCD needs re-addressing.
            RS       <= 1'b0;
            Dados    <= cmd_wrap;
            longa    <= 1'b0;
            pendente <= 1'b0;
        end
    end

    lcd_pulso_e #(
        .T_SETUP (T_SETUP),
        .T_PULSO (T_PULSO),
        .T_HOLD  (T_HOLD),
        .CW      (CW)
    ) u_pulso (
        .Clock     (Clock),
        .Reset     (Reset),
        .Inicio    (inicio),
        .Espera    (espera),
        .Estado    (estado),
        .Enable    (Enable),
        .Concluido (concluido)
    );

endmodule

// File: tb/tb_lcd_escritor_caracteres.sv
// Scoreboard bench for lcd_escritor_caracteres: every expected Enable pulse (RS, Dados)
// is queued at request time and popped when the DUT raises Enable.
module tb_lcd_escritor_caracteres;

    localparam int T_SETUP = 2;
    localparam int T_PULSO = 3;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 10;
    localparam int T_CLEAR = 50;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Inicializado;
    logic       Valido;
    logic [7:0] Dado;
    logic       Comando;
    logic       Pronto;
    logic       Enable;
    logic       RS;
    logic       RW;
    logic [7:0] Dados;
    logic [4:0] Cursor;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] esperado_q[$];
    logic [8:0] esperado;
    logic       en_ant = 1'b0;
    logic [4:0] cur_mod = 5'd0;

    always #5 Clock = ~Clock;

    lcd_escritor_caracteres #(
        .T_SETUP (T_SETUP),
        .T_PULSO (T_PULSO),
        .T_HOLD  (T_HOLD),
        .T_EXEC  (T_EXEC),
        .T_CLEAR (T_CLEAR)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Inicializado (Inicializado),
        .Valido       (Valido),
        .Dado         (Dado),
        .Comando      (Comando),
        .Pronto       (Pronto),
        .Enable       (Enable),
        .RS           (RS),
        .RW           (RW),
        .Dados        (Dados),
        .Cursor       (Cursor)
    );

    // Each rising Enable must match the oldest queued {RS, Dados}.
    always @(negedge Clock) begin
        if (Enable === 1'b1 && en_ant !== 1'b1) begin
            checks++;
            if (esperado_q.size() == 0) begin
                errors++;
                $display("FAIL pulso_inesperado rs=%b dados=%02h required=none", RS, Dados);
            end else begin
                esperado = esperado_q.pop_front();
                if ({RS, Dados} !== esperado) begin
                    errors++;
                    $display("FAIL pulso_conteudo rs=%b dados=%02h required rs=%b dados=%02h",
                             RS, Dados, esperado[8], esperado[7:0]);
                end
            end
        end
        en_ant <= Enable;
    end

    function automatic logic [4:0] cursor_esperado(input logic [4:0] c, input logic [7:0] d,
                                                   input logic cmd);
        if (!cmd) return c + 5'd1;
        if (d == 8'h01 || d == 8'h02 || d == 8'h03) return 5'd0;
        if (d >= 8'h80 && d <= 8'h8F) return 5'(d - 8'h80);
        if (d >= 8'hC0 && d <= 8'hCF) return 5'(d - 8'hC0 + 8'd16);
        return c;
    endfunction

    // Call at a negedge; returns at the negedge right after the accept edge.
    task automatic enviar(input logic [7:0] d, input logic c);
        int n;
        n = 0;
        while (Pronto !== 1'b1 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        checks++;
        if (Pronto !== 1'b1) begin
            errors++;
            $display("FAIL espera_pronto pronto=%b required=1", Pronto);
            return;
        end
        Valido  = 1'b1;
        Dado    = d;
        Comando = c;
        esperado_q.push_back({~c, d});
        cur_mod = cursor_esperado(cur_mod, d, c);
`ifdef LCD_AUTOWRAP_EN
        if (!c && (cur_mod == 5'd16 || cur_mod == 5'd0))
            esperado_q.push_back({1'b0, (cur_mod == 5'd16) ? 8'hC0 : 8'h80});
`endif
        @(posedge Clock);
        @(negedge Clock);
        Valido = 1'b0;
    endtask

    // Returns the number of negedges waited until Pronto rose.
    task automatic aguardar_pronto(output int n);
        n = 0;
        while (Pronto !== 1'b1 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        checks++;
        if (Pronto !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pronto pronto=%b required=1", Pronto);
        end
    endtask

    task automatic test_reset();
        Reset        = 1'b1;
        Inicializado = 1'b0;
        Valido       = 1'b0;
        Dado         = 8'h00;
        Comando      = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if ({Enable, RS, RW, Dados, Cursor, Pronto} !== 17'd0) begin
            errors++;
            $display("FAIL reset en=%b rs=%b rw=%b dados=%02h cursor=%0d pronto=%b required all 0",
                     Enable, RS, RW, Dados, Cursor, Pronto);
        end
        Reset = 1'b0;
        Inicializado = 1'b1;
        #1;
        checks++;
        if (Pronto !== 1'b1) begin
            errors++;
            $display("FAIL pronto_apos_init pronto=%b required=1", Pronto);
        end
        @(negedge Clock);
    endtask

    task automatic test_escrita_dado();
        enviar(8'h41, 1'b0);
        checks++;
        if (RS !== 1'b1 || Dados !== 8'h41) begin
            errors++;
            $display("FAIL dado_latched rs=%b dados=%02h required rs=1 dados=41", RS, Dados);
        end
        // Iteration i samples the interval following edge k+i.
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge Clock);
            checks++;
            if (Enable !== (i >= 2 && i <= 4) || Pronto !== (i == 17)) begin
                errors++;
                $display("FAIL temporizacao ciclo=k+%0d en=%b pronto=%b required en=%b pronto=%b",
                         i + 1, Enable, Pronto, (i >= 2 && i <= 4), (i == 17));
            end
        end
        checks++;
        if (Cursor !== 5'd1) begin
            errors++;
            $display("FAIL cursor_dado cursor=%0d required=1", Cursor);
        end
    endtask

    task automatic test_limpa();
        int n;
        enviar(8'h01, 1'b1);
        checks++;
        if (RS !== 1'b0 || Dados !== 8'h01) begin
            errors++;
            $display("FAIL limpa_rs rs=%b dados=%02h required rs=0 dados=01", RS, Dados);
        end
        aguardar_pronto(n);
        checks++;
        if (n + 1 != 58) begin
            errors++;
            $display("FAIL limpa_latencia ciclos=%0d required=58", n + 1);
        end
        checks++;
        if (Cursor !== 5'd0) begin
            errors++;
            $display("FAIL limpa_cursor cursor=%0d required=0", Cursor);
        end
    endtask

    task automatic test_comandos_cursor();
        int n;
        logic [7:0] cmds[4] = '{8'hC5, 8'h8A, 8'h18, 8'hCF};
        logic [4:0] esp[4]  = '{5'd21, 5'd10, 5'd10, 5'd31};
        for (int j = 0; j < 4; j++) begin
            enviar(cmds[j], 1'b1);
            if (j == 0) begin
                // Pulse Valido while busy; it must be ignored.
                repeat (3) @(negedge Clock);
                Valido  = 1'b1;
                Dado    = 8'h42;
                Comando = 1'b0;
                @(negedge Clock);
                Valido = 1'b0;
            end
            aguardar_pronto(n);
            checks++;
            if (Cursor !== esp[j]) begin
                errors++;
                $display("FAIL cursor_cmd cmd=%02h cursor=%0d required=%0d", cmds[j], Cursor, esp[j]);
            end
        end
        enviar(8'h5A, 1'b0);
        aguardar_pronto(n);
        checks++;
        if (Cursor !== 5'd0) begin
            errors++;
            $display("FAIL cursor_31_para_0 cursor=%0d required=0", Cursor);
        end
    endtask

    task automatic test_autowrap();
        int n;
        enviar(8'h80, 1'b1);
        aguardar_pronto(n);
        for (int i = 0; i < 32; i++) begin
            enviar(8'h30 + 8'(i), 1'b0);
            aguardar_pronto(n);
            if (i == 15) begin
                checks++;
                if (Cursor !== 5'd16) begin
                    errors++;
                    $display("FAIL wrap_cursor16 cursor=%0d required=16", Cursor);
                end
            end
        end
        checks++;
        if (Cursor !== 5'd0 || esperado_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_cursor0 cursor=%0d pendentes=%0d required cursor=0 pendentes=0",
                     Cursor, esperado_q.size());
        end
    endtask

    task automatic test_inicializado();
        int n;
        Inicializado = 1'b0;
        Valido       = 1'b1;
        Dado         = 8'h33;
        Comando      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            checks++;
            if (Pronto !== 1'b0 || Enable !== 1'b0) begin
                errors++;
                $display("FAIL sem_init pronto=%b en=%b required 0 0", Pronto, Enable);
            end
        end
        Valido       = 1'b0;
        Inicializado = 1'b1;
        @(negedge Clock);
        enviar(8'h34, 1'b0);
        repeat (3) @(negedge Clock);
        Inicializado = 1'b0;
        repeat (30) @(negedge Clock);
        checks++;
        if (Pronto !== 1'b0 || esperado_q.size() != 0 || Cursor !== cur_mod) begin
            errors++;
            $display("FAIL init_cai pronto=%b pendentes=%0d cursor=%0d required 0 0 %0d",
                     Pronto, esperado_q.size(), Cursor, cur_mod);
        end
        Inicializado = 1'b1;
        #1;
        checks++;
        if (Pronto !== 1'b1) begin
            errors++;
            $display("FAIL init_volta pronto=%b required=1", Pronto);
        end
        @(negedge Clock);
    endtask

    task automatic test_reset_meio();
        int n;
        enviar(8'h55, 1'b0);
        n = 0;
        while (Enable !== 1'b1 && n < 10) begin
            @(negedge Clock);
            n++;
        end
        checks++;
        if (Enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_meio_pulso en=%b required=1", Enable);
        end
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (Enable !== 1'b0 || Dados !== 8'h00 || Cursor !== 5'd0 || RS !== 1'b0) begin
            errors++;
            $display("FAIL reset_meio en=%b dados=%02h cursor=%0d rs=%b required 0 00 0 0",
                     Enable, Dados, Cursor, RS);
        end
        Reset   = 1'b0;
        cur_mod = 5'd0;
        @(negedge Clock);
        enviar(8'h61, 1'b0);
        aguardar_pronto(n);
        checks++;
        if (Cursor !== 5'd1) begin
            errors++;
            $display("FAIL apos_reset_cursor cursor=%0d required=1", Cursor);
        end
    endtask

    initial begin
        test_reset();
        test_escrita_dado();
        test_limpa();
        test_comandos_cursor();
        test_autowrap();
        test_inicializado();
        test_reset_meio();
        repeat (5) @(negedge Clock);
        checks++;
        if (esperado_q.size() != 0) begin
            errors++;
            $display("FAIL pulsos_faltando pendentes=%0d required=0", esperado_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_escritor_caracteres.md
LCD_ESCRITOR_CARACTERES -- requirements
Module: lcd_escritor_caracteres

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, cycles RS/Dados are stable before Enable rises.
REQ-002 SHALL have parameter T_PULSO, default 12, cycles Enable is high.
REQ-003 SHALL have parameter T_HOLD, default 2, cycles RS/Dados are held after Enable falls.
REQ-004 SHALL have parameter T_EXEC, default 2000, post-pulse wait for ordinary writes/commands.
REQ-005 SHALL have parameter T_CLEAR, default 80000, post-pulse wait for clear (0x01) and home (0x02/0x03).
REQ-006 SHALL use one clock; reset is synchronous and active-high: Clock  in  1  rising-edge clock.
REQ-007 SHALL have Reset  in  1  synchronous active-high reset.
REQ-008 SHALL have Inicializado  in  1  high once the LCD power-up sequence is complete.
REQ-009 SHALL have Valido  in  1  request valid; Dado  in  8  character or instruction byte; Comando  in  1  1 = instruction (RS=0), 0 = data (RS=1).
REQ-010 SHALL have Pronto  out  1  ready to accept a request.
REQ-011 SHALL have Enable  out  1  LCD E; RS  out  1; RW  out  1 (constant 0); Dados  out  8  LCD DB7..DB0.
REQ-012 SHALL have Cursor  out  5  tracked position 0..31 (0-15 line 1, 16-31 line 2).

Function
REQ-013 SHALL implement states OCIOSO, SETUP, PULSO, HOLD, ESPERA, driven by one down-counter sized for the largest parameter.
REQ-014 Pronto SHALL be 1 only in OCIOSO with Inicializado=1 and no pending wrap command.
REQ-015 Accept SHALL occur on an edge sampling Valido=1 and Pronto=1; Dado/Comando are latched and Pronto is 0 from the next cycle.
REQ-016 After accept: SETUP for T_SETUP cycles (RS/Dados driven), PULSO for T_PULSO cycles (Enable=1), HOLD for T_HOLD cycles, then ESPERA for T_CLEAR or T_EXEC cycles.
REQ-017 Pronto SHALL reassert exactly T_SETUP+T_PULSO+T_HOLD+wait+1 cycles after the accept edge, absent a wrap.
REQ-018 Enable SHALL be 1 only in PULSO; RS and Dados SHALL hold their last value outside transactions.
REQ-019 Valido while Pronto=0 SHALL be ignored; the requester must hold it.
REQ-020 Cursor updates: data write increments; 0x01/0x02/0x03 sets 0; 0x80|a with a in 0x00-0x0F sets a, with a in 0x40-0x4F sets a-0x30; other instructions leave it unchanged.
REQ-021 Inicializado falling mid-transaction SHALL NOT abort it; Pronto stays 0 until Inicializado returns.

Reset
REQ-022 On Reset: state OCIOSO, Enable=0, RS=0, Dados=0, Cursor=0, counter 0, pending wrap cleared.
REQ-023 Reset asserted mid-transaction SHALL take effect at the next edge and abort it.

Configuration
REQ-024 Macro LCD_AUTOWRAP_EN: when defined, a data write leaving Cursor at 16 or 0 (from 15 or 31) SHALL be followed by an internal instruction 0xC0 or 0x80 respectively, run through SETUP..ESPERA with T_EXEC before Pronto reasserts.
REQ-025 Without LCD_AUTOWRAP_EN, Cursor SHALL increment modulo 32 and no internal instruction is issued.

Structure
REQ-026 Package lcd_pkg SHALL hold the state encoding and constants CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_DDRAM=0x80, LINHA2=0x40.
REQ-027 Sub-module lcd_pulso_e SHALL implement the SETUP/PULSO/HOLD/ESPERA timing from a start strobe and a wait length, returning a done strobe.

Verification (T_SETUP=2, T_PULSO=3, T_HOLD=2, T_EXEC=10, T_CLEAR=50)
REQ-028 Reset, Inicializado=1, write data 0x41 at accept edge k -> RS=1, Dados=0x41 from k+1, Enable=1 during k+3..k+5, Pronto=1 at k+18, Cursor=1.
REQ-029 Instruction 0x01 -> RS=0, Pronto returns 58 cycles after accept, Cursor=0.
REQ-030 With LCD_AUTOWRAP_EN, 16 data writes -> after the 16th, a second Enable pulse carrying 0xC0, RS=0; Cursor=16; 32 writes -> 0x80, Cursor=0.
REQ-031 Without LCD_AUTOWRAP_EN, 32 writes -> no instruction pulses, Cursor=0.
REQ-032 Inicializado=0 with Valido=1 -> Pronto=0, Enable never rises; on Reset asserted during PULSO -> next cycle Enable=0, Dados=0, Cursor=0.
REQ-033 Instruction 0xC5 -> Cursor=21; Valido pulsed while Pronto=0 -> no second transaction.
